// File: rtl/apb_irq_ctrl.sv
// APB3 interrupt controller: synchronizes NUM_SRC asynchronous sources, applies per-source
// polarity, level/edge type and enable, latches them into a W1C pending register and drives one IRQ.
module apb_irq_ctrl #(
   parameter int NUM_SRC    = 4,
   parameter bit INTACTIVEH = 1'b1
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic               PSEL,
   input  logic               PENABLE,
   input  logic               PWRITE,
   input  logic [4:2]         PADDR,
   input  logic [31:0]        PWDATA,
   output logic [31:0]        PRDATA,
   input  logic [NUM_SRC-1:0] SRC,
   output logic               IRQ
);

   typedef enum logic [2:0] {
      A_RAW      = 3'd0,
      A_ENABLE   = 3'd1,
      A_TYPE     = 3'd2,
      A_POLARITY = 3'd3,
      A_PENDING  = 3'd4,
      A_STATUS   = 3'd5,
      A_IRQID    = 3'd6,
      A_RSVD     = 3'd7
   } reg_addr_e;

   logic [NUM_SRC-1:0] r_s1;
   logic [NUM_SRC-1:0] r_s2;
   logic [NUM_SRC-1:0] r_qd;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_type;
   logic [NUM_SRC-1:0] r_pol;
   logic [NUM_SRC-1:0] r_pending;
   logic               r_irq_int;
   logic [31:0]        r_prdata;

   reg_addr_e          w_addr;
   logic               w_wr_setup;
   logic               w_rd_setup;
   logic [NUM_SRC-1:0] w_q;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_status;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [31:0]        w_irqid;
   logic [31:0]        w_rdata;
   logic               w_unused_pwdata;

   function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
      logic [31:0] r;
      r = '0;
      r[NUM_SRC-1:0] = v;
      return r;
   endfunction

   assign w_addr     = reg_addr_e'(PADDR);
   assign w_wr_setup = PSEL & PWRITE & ~PENABLE;
   assign w_rd_setup = PSEL & ~PWRITE & ~PENABLE;

   // Bits of PWDATA above NUM_SRC are deliberately ignored.
   assign w_unused_pwdata = ^PWDATA;

   assign w_q      = r_s2 ^ r_pol;
   assign w_w1c    = (w_wr_setup && w_addr == A_PENDING) ? PWDATA[NUM_SRC-1:0] : '0;
   assign w_status = r_pending & r_enable;

   // Edge bits: a fresh rising edge wins over a same-cycle W1C. Level bits just follow Q.
   assign w_pending_nxt = (r_type & ((w_q & ~r_qd) | (r_pending & ~w_w1c)))
                        | (~r_type & w_q);

   // NOTE: every flop uses non-blocking assignment so all state updates see pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_qd <= '0;
      end else begin
         r_s1 <= SRC;
         r_s2 <= r_s1;
         r_qd <= w_q;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_enable <= '0;
         r_type   <= '0;
         r_pol    <= '0;
      end else if (w_wr_setup) begin
         case (w_addr)
            A_ENABLE:   r_enable <= PWDATA[NUM_SRC-1:0];
            A_TYPE:     r_type   <= PWDATA[NUM_SRC-1:0];
            A_POLARITY: r_pol    <= PWDATA[NUM_SRC-1:0];
            default:    ;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_pending <= '0;
         r_irq_int <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_irq_int <= |w_status;
      end
   end

   // NOTE: defaults first so no path through the loop can infer a latch.
   always_comb begin
      w_irqid     = '0;
      w_irqid[31] = |w_status;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_status[i]) w_irqid[2:0] = 3'(i);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         A_RAW:      w_rdata = zext(w_q);
         A_ENABLE:   w_rdata = zext(r_enable);
         A_TYPE:     w_rdata = zext(r_type);
         A_POLARITY: w_rdata = zext(r_pol);
         A_PENDING:  w_rdata = zext(r_pending);
         A_STATUS:   w_rdata = zext(w_status);
         A_IRQID:    w_rdata = w_irqid;
         A_RSVD:     w_rdata = '0;
         default:    w_rdata = '0;
      endcase
   end

   // Read data lives for exactly one cycle: captured on the setup edge, zero otherwise.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_prdata <= '0;
      else          r_prdata <= w_rd_setup ? w_rdata : '0;
   end

   assign PRDATA = r_prdata;
   assign IRQ    = INTACTIVEH ? r_irq_int : ~r_irq_int;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Self-checking bench for apb_irq_ctrl: directed steps from the test plan plus randomized traffic
// checked every cycle against a cycle-indexed behavioural model of the register rules.
module tb_apb_irq_ctrl;

   localparam int N    = 4;
   localparam int MAXC = 16384;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [4:2]    PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic [31:0]   PRDATA_L;
   logic [N-1:0]  SRC;
   logic          IRQ;
   logic          IRQ_L;

   apb_irq_ctrl #(.NUM_SRC(N), .INTACTIVEH(1'b1)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .SRC(SRC), .IRQ(IRQ)
   );

   apb_irq_ctrl #(.NUM_SRC(N), .INTACTIVEH(1'b0)) dut_l (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA_L), .SRC(SRC), .IRQ(IRQ_L)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;

   // Model state: register contents plus per-edge history of the sampled source and polarity.
   logic [N-1:0] m_en, m_type, m_pol, m_pend;
   logic         m_irq;
   logic [31:0]  m_prdata;
   int           m_cyc;
   logic [N-1:0] src_smp  [MAXC];
   logic [N-1:0] pol_hist [MAXC];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_en = '0; m_type = '0; m_pol = '0; m_pend = '0;
      m_irq = 1'b0; m_prdata = '0; m_cyc = 0;
   endtask

   // Qualified source level seen just before edge c: SRC from two edges earlier, XOR polarity.
   function automatic logic [N-1:0] q_at(input int c);
      logic [N-1:0] s;
      s = (c >= 2) ? src_smp[c-2] : '0;
      return s ^ pol_hist[c];
   endfunction

   function automatic logic [31:0] model_reg(input logic [2:0] a, input logic [N-1:0] raw);
      logic [31:0]  v;
      logic [N-1:0] st;
      v  = '0;
      st = m_pend & m_en;
      case (a)
         3'd0: v[N-1:0] = raw;
         3'd1: v[N-1:0] = m_en;
         3'd2: v[N-1:0] = m_type;
         3'd3: v[N-1:0] = m_pol;
         3'd4: v[N-1:0] = m_pend;
         3'd5: v[N-1:0] = st;
         3'd6: begin
            v[31] = (st != '0);
            for (int i = 0; i < N; i++) begin
               if (st[i]) begin
                  v[2:0] = i[2:0];
                  break;
               end
            end
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   // Advance one edge: update the model from the inputs driven now, then compare outputs.
   task automatic tick();
      logic [N-1:0] qc, qp, w1c, nxt;
      logic [31:0]  rd;
      logic         irq_n;
      int           c;
      c = m_cyc;
      if (c >= MAXC) begin
         $display("FAIL cycle_budget: observed %0d expected below %0d", c, MAXC);
         $fatal(1);
      end
      src_smp[c]  = SRC;
      pol_hist[c] = m_pol;
      qc  = q_at(c);
      qp  = (c >= 1) ? q_at(c - 1) : '0;
      w1c = (PSEL && PWRITE && !PENABLE && PADDR == 3'd4) ? PWDATA[N-1:0] : '0;
      for (int i = 0; i < N; i++) begin
         if (m_type[i]) nxt[i] = (qc[i] && !qp[i]) || (m_pend[i] && !w1c[i]);
         else           nxt[i] = qc[i];
      end
      rd    = (PSEL && !PWRITE && !PENABLE) ? model_reg(PADDR, qc) : '0;
      irq_n = |(m_pend & m_en);
      if (PSEL && PWRITE && !PENABLE) begin
         case (PADDR)
            3'd1: m_en   = PWDATA[N-1:0];
            3'd2: m_type = PWDATA[N-1:0];
            3'd3: m_pol  = PWDATA[N-1:0];
            default: ;
         endcase
      end
      m_pend   = nxt;
      m_irq    = irq_n;
      m_prdata = rd;
      m_cyc++;
      @(posedge PCLK);
      #1;
      check("irq_model", {31'd0, IRQ}, {31'd0, m_irq});
      check("irq_low_model", {31'd0, IRQ_L}, {31'd0, !m_irq});
      check("prdata_model", PRDATA, m_prdata);
   endtask

   task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      tick();
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      tick();
      d = PRDATA;
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(a, d);
      check(tag, d, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int          op;

      // Reset state
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; SRC = '0;
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      check("rst_irq_low", {31'd0, IRQ_L}, 32'd1);
      check("rst_prdata", PRDATA, 32'd0);
      PRESETn = 1'b1;
      model_reset();
      for (int a = 0; a < 8; a++) rd_chk("rst_reg", 3'(a), 32'd0);

      // Edge source 0
      apb_write(3'd2, 32'h1);
      apb_write(3'd1, 32'h1);
      SRC = 4'b0001;
      tick(); tick(); tick();
      check("edge_irq_k2", {31'd0, IRQ}, 32'd0);
      tick();
      check("edge_irq_k3", {31'd0, IRQ}, 32'd1);
      rd_chk("edge_pending", 3'd4, 32'h1);
      rd_chk("edge_irqid", 3'd6, 32'h8000_0000);
      tick(); tick();
      SRC = 4'b0000;
      repeat (4) tick();
      check("edge_hold", {31'd0, IRQ}, 32'd1);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 3'd4; PWDATA = 32'h1;
      tick();
      check("w1c_irq_w", {31'd0, IRQ}, 32'd1);
      PENABLE = 1'b1;
      tick();
      check("w1c_irq_w1", {31'd0, IRQ}, 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      rd_chk("w1c_pending", 3'd4, 32'h0);

      // Level source 2, active-low
      apb_write(3'd3, 32'h4);
      apb_write(3'd1, 32'h4);
      tick(); tick();
      check("lvl_irq", {31'd0, IRQ}, 32'd1);
      rd_chk("lvl_pending", 3'd4, 32'h4);
      apb_write(3'd4, 32'h4);
      rd_chk("lvl_w1c_ignored", 3'd4, 32'h4);
      SRC = 4'b0100;
      tick(); tick(); tick();
      check("lvl_irq_k2", {31'd0, IRQ}, 32'd1);
      tick();
      check("lvl_irq_k3", {31'd0, IRQ}, 32'd0);
      rd_chk("lvl_pending_clr", 3'd4, 32'h0);

      // Priority and masking
      apb_write(3'd2, 32'hB);
      apb_write(3'd1, 32'hA);
      SRC = 4'b1110;
      repeat (4) tick();
      rd_chk("prio_irqid_1", 3'd6, 32'h8000_0001);
      rd_chk("prio_status", 3'd5, 32'hA);
      apb_write(3'd1, 32'h8);
      rd_chk("prio_irqid_3", 3'd6, 32'h8000_0003);
      apb_write(3'd1, 32'h0);
      rd_chk("mask_irqid", 3'd6, 32'h0);
      check("mask_irq", {31'd0, IRQ}, 32'd0);
      rd_chk("mask_pending", 3'd4, 32'hA);
      SRC = 4'b0100;
      repeat (3) tick();

      // New edge coinciding with W1C
      apb_write(3'd4, 32'hF);
      rd_chk("simul_clr_all", 3'd4, 32'h0);
      SRC = 4'b0101;
      repeat (4) tick();
      rd_chk("simul_pre", 3'd4, 32'h1);
      SRC = 4'b0100;
      repeat (4) tick();
      SRC = 4'b0101;
      tick(); tick();
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 3'd4; PWDATA = 32'h1;
      tick();
      PENABLE = 1'b1;
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      rd_chk("simul_set_wins", 3'd4, 32'h1);
      apb_write(3'd4, 32'h1);
      rd_chk("w1c_after", 3'd4, 32'h0);

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         op = int'($urandom_range(0, 5));
         r  = $urandom;
         case (op)
            0: begin
               SRC = r[N-1:0];
               repeat (2) tick();
            end
            1, 2: apb_write(3'($urandom_range(0, 7)), $urandom);
            3, 4: apb_read(3'($urandom_range(0, 7)), r);
            default: tick();
         endcase
      end

      // Reset in the middle of a read with IRQ asserted
      apb_write(3'd2, 32'h0);
      apb_write(3'd3, 32'h0);
      apb_write(3'd1, 32'hF);
      SRC = 4'b0001;
      repeat (4) tick();
      check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 3'd0;
      tick();
      check("rst_rd_setup", PRDATA, 32'h1);
      PENABLE = 1'b1;
      #2;
      PRESETn = 1'b0;
      #1;
      check("midrst_irq", {31'd0, IRQ}, 32'd0);
      check("midrst_irq_low", {31'd0, IRQ_L}, 32'd1);
      check("midrst_prdata", PRDATA, 32'd0);
      check("midrst_prdata_low", PRDATA_L, 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0; SRC = '0;
      @(posedge PCLK);
      #1;
      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      model_reset();
      apb_write(3'd1, 32'h5);
      rd_chk("post_rst_en", 3'd1, 32'h5);
      rd_chk("post_rst_type", 3'd2, 32'h0);
      rd_chk("post_rst_pending", 3'd4, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_irq_ctrl.md
# apb_irq_ctrl

APB3-slave interrupt controller that sits directly downstream of the APB timer blocks and other fabric peripherals. It consumes their interrupt outputs (for example TIMINT) as asynchronous sources and synchronizes each one. Each source is conditioned with per-source polarity, level/edge type and enable, then latched into a pending register with write-1-to-clear. The block drives one combined, registered interrupt line to the processor and reports the highest-priority active source ID.

## Interface
- NUM_SRC, 4: number of interrupt sources, legal range 1..8; bits [7:NUM_SRC] of every per-source register read 0 and ignore writes.
- INTACTIVEH, 1: 1 = IRQ active high, 0 = IRQ active low.
- PCLK  in  1  APB clock; all flops on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  3 [4:2]  register word address.
- PWDATA  in  32  write data.
- PRDATA  out  32  registered read data.
- SRC  in  NUM_SRC  asynchronous interrupt sources, e.g. timer TIMINT.
- IRQ  out  1  combined interrupt, polarity set by INTACTIVEH.

## Operation
- Register access:
  - A write takes effect at the PCLK edge where PSEL && PWRITE && !PENABLE (setup phase).
  - Read data is captured into PRDATA at the edge where PSEL && !PWRITE && !PENABLE. PRDATA is 0 on all other edges.
- Register map (PADDR[4:2]):
  - 0 RAW (RO): qualified synchronized source levels.
  - 1 ENABLE (RW).
  - 2 TYPE (RW): 1 = edge, 0 = level.
  - 3 POLARITY (RW): 1 = source active-low.
  - 4 PENDING (RO for level bits; W1C for edge bits).
  - 5 STATUS (RO) = PENDING & ENABLE.
  - 6 IRQID (RO): bit31 = any STATUS bit set; [2:0] = lowest-numbered set STATUS bit, 0 when none set.
  - 7 reads 0.
- Source path, per bit:
  - Two-flop synchronizer S1 -> S2.
  - Q = S2 ^ POLARITY.
  - Qd = Q delayed by one flop.
- Pending update, per bit, every edge:
  - Level type: PENDING <= Q. W1C has no effect.
  - Edge type: PENDING <= (Q & !Qd) | (PENDING & !w1c). A new edge and a W1C of the same bit on the same cycle leave PENDING = 1 (set wins).
- Register writes:
  - Changing TYPE does not clear PENDING. The next update applies the new rule.
  - Changing POLARITY can create an edge on Q; the resulting pending bit is legal, and software clears it.
  - Disabling a source masks STATUS and IRQ only; PENDING keeps latching.
- IRQ_int <= |(PENDING & ENABLE), registered. IRQ = INTACTIVEH ? IRQ_int : !IRQ_int.

## Timing
- Reset values:
  - S1, S2, Qd, PENDING, ENABLE, TYPE, POLARITY, PRDATA = 0.
  - IRQ_int = 0, so IRQ = 0 (INTACTIVEH=1) or 1 (INTACTIVEH=0).
- Reset is asynchronous and applies from any state, including mid-transfer. After release, the first APB setup phase is honoured.
- Source latency, with SRC rising before edge k:
  - S1 = 1 at edge k.
  - S2 = 1 at edge k+1.
  - PENDING = 1 at edge k+2.
  - IRQ asserted after edge k+3.
- A SRC pulse shorter than 2 PCLK periods may be missed. Sources must hold for at least 2 PCLK cycles.
- W1C latency: a setup phase at edge w clears an edge-type PENDING at edge w, and IRQ deasserts after edge w+1 if nothing else is pending.
- Level-type deassert: same latency as assert. IRQ deasserts 4 edges after SRC falls.
- Read data:
  - PRDATA holds the value sampled at the setup edge throughout the access phase.
  - PRDATA returns to 0 at the next edge that is not a read setup phase.
- STATUS and IRQID reflect PENDING as it stood before the read's setup edge.

## Test plan
- Reset: hold PRESETn low, then release. Registers 0..7 read 0 and IRQ = 0. With INTACTIVEH=0, IRQ = 1.
- Edge source: write TYPE=0x1, ENABLE=0x1, then pulse SRC[0] high for 10 cycles.
  - PENDING=0x1 at k+2 and IRQ high after k+3.
  - IRQID reads 0x8000_0000.
  - Write 0x1 to reg 4: PENDING=0, and IRQ low 2 edges later.
- Level source with polarity: write POLARITY=0x4, ENABLE=0x4, then drive SRC[2]=0.
  - PENDING=0x4 and IRQ high.
  - W1C of 0x4 leaves PENDING=0x4.
  - Drive SRC[2]=1: PENDING=0, and IRQ low 4 edges after the change.
- Priority and masking: pend sources 1 and 3, ENABLE=0xA.
  - IRQID = 0x8000_0001 and STATUS=0xA.
  - Write ENABLE=0x8: IRQID = 0x8000_0003.
  - Write ENABLE=0: IRQID = 0 and IRQ low; PENDING is unchanged.
- Simultaneous set/clear: edge-type source 0 with an existing pending bit. Align the new edge with a W1C setup edge; PENDING[0] stays 1.
- Reset mid-operation: with IRQ asserted and a read in its access phase, pulse PRESETn low. All outputs return to reset values immediately, without waiting for a clock edge.
